// File: rtl/load_scheduler_pkg.sv
// Shared definitions for the load scheduler and the switch-matrix FSM bench.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package load_scheduler_pkg;

    // Codes driven onto the switch-matrix FSM DesiredLoad input.
    typedef enum logic [1:0] {
        LD_NUL = 2'b00,
        LD_LAA = 2'b01,
        LD_LBB = 2'b10,
        LD_LCC = 2'b11
    } load_t;

    // Bit positions in req/grant.
    localparam int REQ_AA = 0;
    localparam int REQ_BB = 1;
    localparam int REQ_CC = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SWITCH  = 3'd1,
        ST_DWELL   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    // Next requester index modulo 3.
    function automatic logic [1:0] inc3(input logic [1:0] i);
        return (i >= 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // One-hot requester vector to index; an all-zero vector maps to AA.
    function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
        if (oh[REQ_CC])      return 2'd2;
        else if (oh[REQ_BB]) return 2'd1;
        else                 return 2'd0;
    endfunction

    // Requester index to matrix load code (AA->LAA, BB->LBB, CC->LCC).
    function automatic load_t idx_to_load(input logic [1:0] idx);
        return load_t'(idx + 2'd1);
    endfunction

endpackage

// File: rtl/load_scheduler_rr_arbiter3.sv
// Three-way round-robin pick: search ptr+1, ptr+2, then ptr itself (mod 3).
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides whether to act on win_vld.
// Ports: req (requests), ptr (last winner), excl (exclude ptr from the search),
//        win (one-hot winner), win_vld (any winner found).
module rr_arbiter3
    import load_scheduler_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    input  logic       excl,
    output logic [2:0] win,
    output logic       win_vld
);

    logic [1:0] cand1;
    logic [1:0] cand2;

    always_comb begin
        cand1 = inc3(ptr);
        cand2 = inc3(cand1);
        win   = 3'b000;
        if (req[cand1])
            win[cand1] = 1'b1;
        else if (req[cand2])
            win[cand2] = 1'b1;
        else if (!excl && req[ptr])
            win[ptr] = 1'b1;
    end

    assign win_vld = |win;

endmodule

// File: rtl/load_scheduler.sv
// Round-robin sequencer choosing which requester drives the switch matrix, with settle/dwell/fault holds.
// Latency: grant and desired_load registered one edge after req is sampled in IDLE.
// Backpressure: req is level-held by requesters and ignored while switching, dwelling or faulted.
// Ports: clk, rst (async, high), req[2:0] (AA/BB/CC), short_in; desired_load[1:0] to FSM,
//        grant[2:0] one-hot owner, busy (matrix switching), fault (short lockout).
module load_scheduler
    import load_scheduler_pkg::*;
#(
    parameter int SETTLE_CYCLES = 8,
    parameter int DWELL_CYCLES  = 16,
    parameter int FAULT_HOLD    = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       short_in,
    output logic [1:0] desired_load,
    output logic [2:0] grant,
    output logic       busy,
    output logic       fault
);

    localparam int MAX_SD = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
    localparam int MAX_C  = (MAX_SD > FAULT_HOLD) ? MAX_SD : FAULT_HOLD;
    localparam int CW     = $clog2(MAX_C + 1);

    // The "last" values mark the edge on which the Nth count completes.
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_LAST  = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_SAT   = CW'(DWELL_CYCLES);
    localparam logic [CW-1:0] FAULT_LAST  = CW'(FAULT_HOLD - 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [1:0]    ptr, ptr_nx;
    load_t         load_nx;
    logic [2:0]    grant_nx;
    logic          busy_nx;
    logic          fault_nx;

    logic [2:0]    win;
    logic          win_vld;
    logic          excl;

    // In DWELL the owner (== ptr) may only keep the matrix, never re-win it.
    assign excl = (state == ST_DWELL);

    rr_arbiter3 u_arb (
        .req     (req),
        .ptr     (ptr),
        .excl    (excl),
        .win     (win),
        .win_vld (win_vld)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            ptr          <= 2'd2;
            desired_load <= LD_NUL;
            grant        <= 3'b000;
            busy         <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            ptr          <= ptr_nx;
            desired_load <= load_nx;
            grant        <= grant_nx;
            busy         <= busy_nx;
            fault        <= fault_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        ptr_nx   = ptr;
        load_nx  = load_t'(desired_load);
        grant_nx = grant;
        busy_nx  = busy;
        fault_nx = fault;

        // A short pre-empts everything; inside FAULT it must not restart the hold.
        if (short_in && state != ST_FAULT) begin
            state_nx = ST_FAULT;
            cnt_nx   = '0;
            load_nx  = LD_NUL;
            grant_nx = 3'b000;
            busy_nx  = 1'b0;
            fault_nx = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    load_nx  = LD_NUL;
                    grant_nx = 3'b000;
                    busy_nx  = 1'b0;
                    fault_nx = 1'b0;
                    if (win_vld) begin
                        state_nx = ST_SWITCH;
                        cnt_nx   = '0;
                        ptr_nx   = onehot_to_idx(win);
                        load_nx  = idx_to_load(onehot_to_idx(win));
                        grant_nx = win;
                        busy_nx  = 1'b1;
                    end
                end
                ST_SWITCH: begin
                    if (cnt >= SETTLE_LAST) begin
                        state_nx = ST_DWELL;
                        cnt_nx   = '0;
                        busy_nx  = 1'b0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                ST_DWELL: begin
                    if (cnt >= DWELL_LAST) begin
                        if (win_vld) begin
                            // Drive the new code directly; the FSM walks through NUL itself.
                            state_nx = ST_SWITCH;
                            cnt_nx   = '0;
                            ptr_nx   = onehot_to_idx(win);
                            load_nx  = idx_to_load(onehot_to_idx(win));
                            grant_nx = win;
                            busy_nx  = 1'b1;
                        end else if (|(req & grant)) begin
                            cnt_nx = DWELL_SAT;
                        end else begin
                            state_nx = ST_RELEASE;
                            cnt_nx   = '0;
                            load_nx  = LD_NUL;
                            grant_nx = 3'b000;
                            busy_nx  = 1'b1;
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt >= SETTLE_LAST) begin
                        state_nx = ST_IDLE;
                        cnt_nx   = '0;
                        busy_nx  = 1'b0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (cnt >= FAULT_LAST) begin
                        // Hold expired: counter stays put until the short clears.
                        if (!short_in) begin
                            state_nx = ST_IDLE;
                            cnt_nx   = '0;
                            fault_nx = 1'b0;
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                    load_nx  = LD_NUL;
                    grant_nx = 3'b000;
                    busy_nx  = 1'b0;
                    fault_nx = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_scheduler.sv
module tb_load_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic       short_in;
    logic [1:0] desired_load;
    logic [2:0] grant;
    logic       busy;
    logic       fault;

    int errors = 0;
    int checks = 0;

    load_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .short_in     (short_in),
        .desired_load (desired_load),
        .grant        (grant),
        .busy         (busy),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    // One rising edge, then sample/drive 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        req      = 3'b000;
        short_in = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req      = 3'b000;
        short_in = 1'b0;
        rst      = 1'b1;
        #2;
        checks++;
        if ({desired_load, grant, busy, fault} !== 7'b0) begin
            errors++;
            $display("FAIL reset_async: got dl=%b g=%b b=%b f=%b, want all zero", desired_load, grant, busy, fault);
        end
        req = 3'b111;
        tick();
        checks++;
        if ({desired_load, grant, busy, fault} !== 7'b0) begin
            errors++;
            $display("FAIL reset_held: got dl=%b g=%b b=%b f=%b, want all zero", desired_load, grant, busy, fault);
        end
        rst = 1'b0;
        req = 3'b000;
    endtask

    task automatic test_single();
        do_reset();
        req = 3'b001;
        tick(); // edge 0
        checks++;
        if (desired_load !== 2'b01 || grant !== 3'b001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_edge0: got dl=%b g=%b b=%b, want 01 001 1", desired_load, grant, busy);
        end
        ticks(7); // edge 7
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_e7: got %b, want 1", busy);
        end
        tick(); // edge 8
        checks++;
        if (busy !== 1'b0 || grant !== 3'b001) begin
            errors++;
            $display("FAIL single_busy_e8: got b=%b g=%b, want 0 001", busy, grant);
        end
    endtask

    task automatic test_contention();
        logic [2:0] exp_g [4];
        logic [1:0] exp_d [4];
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
        exp_d[0] = 2'b01;  exp_d[1] = 2'b10;  exp_d[2] = 2'b11;  exp_d[3] = 2'b01;
        do_reset();
        req = 3'b111;
        tick(); // edge 0
        checks++;
        if (grant !== exp_g[0] || desired_load !== exp_d[0]) begin
            errors++;
            $display("FAIL rr_grant0: got g=%b dl=%b, want %b %b", grant, desired_load, exp_g[0], exp_d[0]);
        end
        for (int k = 1; k < 4; k++) begin
            ticks(23);
            checks++;
            if (grant !== exp_g[k-1]) begin
                errors++;
                $display("FAIL rr_hold%0d: got g=%b, want %b", k, grant, exp_g[k-1]);
            end
            tick();
            checks++;
            if (grant !== exp_g[k] || desired_load !== exp_d[k] || busy !== 1'b1) begin
                errors++;
                $display("FAIL rr_grant%0d: got g=%b dl=%b b=%b, want %b %b 1", k, grant, desired_load, busy, exp_g[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_sole();
        int bad = 0;
        do_reset();
        req = 3'b010;
        tick(); // edge 0
        checks++;
        if (grant !== 3'b010 || desired_load !== 2'b10) begin
            errors++;
            $display("FAIL sole_edge0: got g=%b dl=%b, want 010 10", grant, desired_load);
        end
        ticks(8);
        for (int i = 0; i < 92; i++) begin
            if (grant !== 3'b010 || busy !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL sole_stable: %0d bad cycles, want 0", bad);
        end
    endtask

    task automatic test_release();
        do_reset();
        req = 3'b001;
        tick(); // edge 0
        ticks(5);
        req = 3'b000;
        ticks(18); // edge 23
        checks++;
        if (grant !== 3'b001 || desired_load !== 2'b01) begin
            errors++;
            $display("FAIL rel_hold_e23: got g=%b dl=%b, want 001 01", grant, desired_load);
        end
        tick(); // edge 24
        checks++;
        if (desired_load !== 2'b00 || grant !== 3'b000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rel_enter_e24: got dl=%b g=%b b=%b, want 00 000 1", desired_load, grant, busy);
        end
        ticks(7); // edge 31
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rel_busy_e31: got %b, want 1", busy);
        end
        tick(); // edge 32 -> IDLE
        checks++;
        if (busy !== 1'b0 || grant !== 3'b000 || desired_load !== 2'b00) begin
            errors++;
            $display("FAIL rel_idle_e32: got b=%b g=%b dl=%b, want 0 000 00", busy, grant, desired_load);
        end
        req = 3'b100;
        tick(); // edge 33: pointer at AA, CC wins
        checks++;
        if (grant !== 3'b100 || desired_load !== 2'b11) begin
            errors++;
            $display("FAIL rel_rearm_e33: got g=%b dl=%b, want 100 11", grant, desired_load);
        end
    endtask

    task automatic test_short_switch();
        // Short sampled on edges 3..9.
        do_reset();
        req = 3'b001;
        tick(); // edge 0
        ticks(2);
        short_in = 1'b1;
        tick(); // edge 3
        checks++;
        if (desired_load !== 2'b00 || fault !== 1'b1 || grant !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL short_enter_e3: got dl=%b f=%b g=%b b=%b, want 00 1 000 0", desired_load, fault, grant, busy);
        end
        ticks(6); // edge 9
        short_in = 1'b0;
        ticks(25); // edge 34
        checks++;
        if (fault !== 1'b1) begin
            errors++;
            $display("FAIL short_hold_e34: got %b, want 1", fault);
        end
        tick(); // edge 35
        checks++;
        if (fault !== 1'b0 || desired_load !== 2'b00) begin
            errors++;
            $display("FAIL short_exit_e35: got f=%b dl=%b, want 0 00", fault, desired_load);
        end
        tick(); // edge 36: re-armed from IDLE, pointer kept at AA
        checks++;
        if (grant !== 3'b001 || desired_load !== 2'b01) begin
            errors++;
            $display("FAIL short_regrant_e36: got g=%b dl=%b, want 001 01", grant, desired_load);
        end
    endtask

    task automatic test_short_long();
        // Short sampled on edges 3..50.
        do_reset();
        req = 3'b001;
        tick(); // edge 0
        ticks(2);
        short_in = 1'b1;
        ticks(33); // edge 35
        checks++;
        if (fault !== 1'b1) begin
            errors++;
            $display("FAIL shortlong_e35: got %b, want 1", fault);
        end
        ticks(15); // edge 50
        short_in = 1'b0;
        checks++;
        if (fault !== 1'b1) begin
            errors++;
            $display("FAIL shortlong_e50: got %b, want 1", fault);
        end
        tick(); // edge 51
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL shortlong_e51: got %b, want 0", fault);
        end
    endtask

    task automatic test_short_vs_req();
        do_reset();
        req      = 3'b010;
        short_in = 1'b1;
        tick();
        checks++;
        if (fault !== 1'b1 || grant !== 3'b000 || desired_load !== 2'b00) begin
            errors++;
            $display("FAIL short_vs_req: got f=%b g=%b dl=%b, want 1 000 00", fault, grant, desired_load);
        end
        short_in = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 3'b001;
        tick(); // edge 0
        ticks(12); // mid-DWELL
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({desired_load, grant, busy, fault} !== 7'b0) begin
            errors++;
            $display("FAIL async_rst: got dl=%b g=%b b=%b f=%b, want all zero", desired_load, grant, busy, fault);
        end
        req = 3'b111;
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (grant !== 3'b001 || desired_load !== 2'b01) begin
            errors++;
            $display("FAIL async_rst_prio: got g=%b dl=%b, want 001 01", grant, desired_load);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_sole();
        test_release();
        test_short_switch();
        test_short_long();
        test_short_vs_req();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
